// File: rtl/map_table.sv
// -----------------------------------------------------------------------------
// map_table: 3-wide register rename map table (dispatch stage).
//
// Translates source architectural registers into physical tags plus ready
// bits, installs the free list's newly allocated tags as destination mappings
// and reports the previous destination mapping (told) to the ROB. Ready bits
// are set by CDB broadcasts. Branch recovery restores the table from the
// retirement map.
//
// Ports (lane 2 is oldest, lane 0 youngest; lane L occupies bits [L*w +: w]):
//   clock, reset       system clock, synchronous active-high reset
//   dispatch_en        per-lane dispatch valid
//   dest_areg          destination architectural register per lane
//   src1_areg          source 1 architectural register per lane
//   src2_areg          source 2 architectural register per lane
//   free_preg          tag allocated by the free list per lane
//   cdb_en, cdb_preg   CDB broadcast valid and completing tag per way
//   recover_en         restore the table from arch_map
//   arch_map           retirement map contents (entry i at [i*PR +: PR])
//   src1_preg/ready    renamed source 1 tag and availability (combinational)
//   src2_preg/ready    renamed source 2 tag and availability (combinational)
//   told_preg          previous mapping of each destination (combinational)
//   map_display        debug view of the map entries
//   ready_display      debug view of the ready bits
// -----------------------------------------------------------------------------
module map_table #(
  parameter int PR     = 6,
  parameter int AR_NUM = 32,
  parameter int WAYS   = 3
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [WAYS-1:0]          dispatch_en,
  input  logic [WAYS*5-1:0]        dest_areg,
  input  logic [WAYS*5-1:0]        src1_areg,
  input  logic [WAYS*5-1:0]        src2_areg,
  input  logic [WAYS*PR-1:0]       free_preg,
  input  logic [WAYS-1:0]          cdb_en,
  input  logic [WAYS*PR-1:0]       cdb_preg,
  input  logic                     recover_en,
  input  logic [AR_NUM*PR-1:0]     arch_map,
  output logic [WAYS*PR-1:0]       src1_preg,
  output logic [WAYS-1:0]          src1_ready,
  output logic [WAYS*PR-1:0]       src2_preg,
  output logic [WAYS-1:0]          src2_ready,
  output logic [WAYS*PR-1:0]       told_preg,
  output logic [AR_NUM*PR-1:0]     map_display,
  output logic [AR_NUM-1:0]        ready_display
);

  localparam int AW = 5;

  logic [PR-1:0]     map_r [AR_NUM];
  logic [AR_NUM-1:0] ready_r;

  // Searches lanes older than 'lane' for a dispatching, non-x0 write of
  // 'areg'. Scanning oldest to youngest lets the youngest match overwrite.
  // Returns {hit, tag}.
  function automatic logic [PR:0] older_match(
    input logic [AW-1:0]      areg,
    input int                 lane,
    input logic [WAYS-1:0]    en,
    input logic [WAYS*AW-1:0] dest,
    input logic [WAYS*PR-1:0] fr
  );
    logic [PR:0] result;
    result = {1'b0, {PR{1'b0}}};
    for (int k = WAYS - 1; k > lane; k--) begin
      result = (en[k] && (dest[k*AW +: AW] == areg) && (areg != {AW{1'b0}}))
               ? {1'b1, fr[k*PR +: PR]} : result;
    end
    return result;
  endfunction

  // True when any valid CDB way broadcasts 'tag'.
  function automatic logic cdb_hit(
    input logic [PR-1:0]      tag,
    input logic [WAYS-1:0]    en,
    input logic [WAYS*PR-1:0] bus
  );
    logic hit;
    hit = 1'b0;
    for (int w = 0; w < WAYS; w++) begin
      hit = hit | (en[w] && (bus[w*PR +: PR] == tag));
    end
    return hit;
  endfunction

  // Rename lookup: in-group overrides first, otherwise map entry with CDB bypass.
  always_comb begin
    logic [PR:0]   ovr;
    logic [AW-1:0] idx;
    src1_preg  = '0;
    src1_ready = '0;
    src2_preg  = '0;
    src2_ready = '0;
    told_preg  = '0;
    for (int l = 0; l < WAYS; l++) begin
      idx = src1_areg[l*AW +: AW];
      ovr = older_match(idx, l, dispatch_en, dest_areg, free_preg);
      if (ovr[PR]) begin
        src1_preg[l*PR +: PR] = ovr[PR-1:0];
        src1_ready[l]         = 1'b0;
      end else begin
        src1_preg[l*PR +: PR] = map_r[idx];
        src1_ready[l]         = ready_r[idx] | cdb_hit(map_r[idx], cdb_en, cdb_preg);
      end

      idx = src2_areg[l*AW +: AW];
      ovr = older_match(idx, l, dispatch_en, dest_areg, free_preg);
      if (ovr[PR]) begin
        src2_preg[l*PR +: PR] = ovr[PR-1:0];
        src2_ready[l]         = 1'b0;
      end else begin
        src2_preg[l*PR +: PR] = map_r[idx];
        src2_ready[l]         = ready_r[idx] | cdb_hit(map_r[idx], cdb_en, cdb_preg);
      end

      // An x0 destination hands back its own allocation so the tag is not leaked.
      idx = dest_areg[l*AW +: AW];
      ovr = older_match(idx, l, dispatch_en, dest_areg, free_preg);
      if (idx == {AW{1'b0}}) begin
        told_preg[l*PR +: PR] = free_preg[l*PR +: PR];
      end else if (ovr[PR]) begin
        told_preg[l*PR +: PR] = ovr[PR-1:0];
      end else begin
        told_preg[l*PR +: PR] = map_r[idx];
      end
    end
  end

  // Debug views of the table state.
  always_comb begin
    map_display = '0;
    for (int i = 0; i < AR_NUM; i++) begin
      map_display[i*PR +: PR] = map_r[i];
    end
    ready_display = ready_r;
  end

  // Table update: reset > recovery > (CDB wakeup, then renames; later writes win).
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < AR_NUM; i++) begin
        map_r[i] <= PR'(i);
      end
      ready_r <= '1;
    end else if (recover_en) begin
      for (int i = 0; i < AR_NUM; i++) begin
        map_r[i] <= arch_map[i*PR +: PR];
      end
      ready_r <= '1;
    end else begin
      for (int i = 0; i < AR_NUM; i++) begin
        for (int w = 0; w < WAYS; w++) begin
          if (cdb_en[w] && (map_r[i] == cdb_preg[w*PR +: PR])) begin
            ready_r[i] <= 1'b1;
          end
        end
      end
      // Oldest lane first so the youngest writer of a shared dest lands last.
      for (int k = WAYS - 1; k >= 0; k--) begin
        if (dispatch_en[k] && (dest_areg[k*AW +: AW] != {AW{1'b0}})) begin
          map_r[dest_areg[k*AW +: AW]]   <= free_preg[k*PR +: PR];
          ready_r[dest_areg[k*AW +: AW]] <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_map_table.sv
// -----------------------------------------------------------------------------
// tb_map_table: self-checking bench for map_table. Table-driven rename vectors
// go through a scoreboard queue; hand-written sequences cover the table state,
// recovery and reset-priority corner cases.
// -----------------------------------------------------------------------------
module tb_map_table;

  logic            clock;
  logic            reset;
  logic [2:0]      dispatch_en;
  logic [2:0][4:0] dest_areg;
  logic [2:0][4:0] src1_areg;
  logic [2:0][4:0] src2_areg;
  logic [2:0][5:0] free_preg;
  logic [2:0]      cdb_en;
  logic [2:0][5:0] cdb_preg;
  logic            recover_en;
  logic [31:0][5:0] arch_map;
  logic [2:0][5:0] src1_preg;
  logic [2:0]      src1_ready;
  logic [2:0][5:0] src2_preg;
  logic [2:0]      src2_ready;
  logic [2:0][5:0] told_preg;
  logic [31:0][5:0] map_display;
  logic [31:0]     ready_display;

  int errors = 0;
  int checks = 0;

  map_table dut (
    .clock(clock), .reset(reset), .dispatch_en(dispatch_en),
    .dest_areg(dest_areg), .src1_areg(src1_areg), .src2_areg(src2_areg),
    .free_preg(free_preg), .cdb_en(cdb_en), .cdb_preg(cdb_preg),
    .recover_en(recover_en), .arch_map(arch_map),
    .src1_preg(src1_preg), .src1_ready(src1_ready),
    .src2_preg(src2_preg), .src2_ready(src2_ready),
    .told_preg(told_preg), .map_display(map_display),
    .ready_display(ready_display)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic [2:0]      en;
    logic [2:0][4:0] dest;
    logic [2:0][4:0] s1;
    logic [2:0][4:0] s2;
    logic [2:0][5:0] fr;
    logic [2:0]      cen;
    logic [2:0][5:0] cdb;
    logic [2:0][5:0] e_s1;
    logic [2:0]      e_r1;
    logic [2:0][5:0] e_s2;
    logic [2:0]      e_r2;
    logic [2:0][5:0] e_told;
  } vec_t;

  vec_t vecs [5];
  vec_t sb [$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  task automatic idle_inputs();
    dispatch_en = 3'b000;
    dest_areg   = '0;
    src1_areg   = '0;
    src2_areg   = '0;
    free_preg   = '0;
    cdb_en      = 3'b000;
    cdb_preg    = '0;
    recover_en  = 1'b0;
  endtask

  // Drive one vector, queue its expectations, then compare before the next edge.
  task automatic apply_vec(input int idx);
    vec_t v;
    vec_t e;
    @(negedge clock);
    v = vecs[idx];
    dispatch_en = v.en;
    dest_areg   = v.dest;
    src1_areg   = v.s1;
    src2_areg   = v.s2;
    free_preg   = v.fr;
    cdb_en      = v.cen;
    cdb_preg    = v.cdb;
    recover_en  = 1'b0;
    sb.push_back(v);
    #2;
    if (sb.size() == 0) begin
      chk($sformatf("v%0d_scoreboard_empty", idx), 32'd1, 32'd0);
    end else begin
      e = sb.pop_front();
      for (int l = 0; l < 3; l++) begin
        chk($sformatf("v%0d_src1_preg[%0d]", idx, l), 32'(src1_preg[l]), 32'(e.e_s1[l]));
        chk($sformatf("v%0d_src2_preg[%0d]", idx, l), 32'(src2_preg[l]), 32'(e.e_s2[l]));
        chk($sformatf("v%0d_told_preg[%0d]", idx, l), 32'(told_preg[l]), 32'(e.e_told[l]));
      end
      chk($sformatf("v%0d_src1_ready", idx), 32'(src1_ready), 32'(e.e_r1));
      chk($sformatf("v%0d_src2_ready", idx), 32'(src2_ready), 32'(e.e_r2));
    end
  endtask

  initial begin
    // Post-reset identity lookups; no dispatch.
    vecs[0] = '{3'b000, {5'd22, 5'd12, 5'd7}, {5'd20, 5'd10, 5'd5}, {5'd21, 5'd11, 5'd0},
                {6'd50, 6'd51, 6'd52}, 3'b000, {6'd0, 6'd0, 6'd0},
                {6'd20, 6'd10, 6'd5}, 3'b111, {6'd21, 6'd11, 6'd0}, 3'b111, {6'd22, 6'd12, 6'd7}};
    // Full group, dests 3,3,4: overrides (youngest older wins) and told chaining.
    vecs[1] = '{3'b111, {5'd3, 5'd3, 5'd4}, {5'd3, 5'd3, 5'd3}, {5'd0, 5'd7, 5'd4},
                {6'd32, 6'd33, 6'd34}, 3'b000, {6'd0, 6'd0, 6'd0},
                {6'd3, 6'd32, 6'd33}, 3'b100, {6'd0, 6'd7, 6'd4}, 3'b111, {6'd3, 6'd32, 6'd4}};
    // map[3]=33, map[4]=34 not ready; CDB 33 bypasses same cycle.
    vecs[2] = '{3'b000, {5'd1, 5'd4, 5'd3}, {5'd5, 5'd4, 5'd3}, {5'd6, 5'd3, 5'd4},
                {6'd40, 6'd41, 6'd42}, 3'b001, {6'd0, 6'd0, 6'd33},
                {6'd5, 6'd34, 6'd33}, 3'b101, {6'd6, 6'd33, 6'd34}, 3'b110, {6'd1, 6'd34, 6'd33}};
    // Non-contiguous 101, lane 2 writes x0: told returns its own free tag, no override.
    vecs[3] = '{3'b101, {5'd0, 5'd5, 5'd4}, {5'd3, 5'd4, 5'd0}, {5'd4, 5'd0, 5'd3},
                {6'd40, 6'd41, 6'd42}, 3'b000, {6'd0, 6'd0, 6'd0},
                {6'd33, 6'd34, 6'd0}, 3'b101, {6'd34, 6'd0, 6'd33}, 3'b011, {6'd40, 6'd5, 6'd34}};
    // CDB for 42 and same-cycle rename of reg 4: bypass now, rename's not-ready wins.
    vecs[4] = '{3'b001, {5'd8, 5'd9, 5'd4}, {5'd6, 5'd4, 5'd4}, {5'd7, 5'd5, 5'd3},
                {6'd44, 6'd45, 6'd43}, 3'b011, {6'd0, 6'd42, 6'd34},
                {6'd6, 6'd42, 6'd42}, 3'b111, {6'd7, 6'd5, 6'd33}, 3'b111, {6'd8, 6'd9, 6'd42}};

    idle_inputs();
    for (int i = 0; i < 32; i++) begin
      arch_map[i] = (i == 0) ? 6'd0 : 6'(i + 1);
    end
    reset = 1'b1;
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset = 1'b0;

    chk("reset_ready_display", ready_display, 32'hFFFF_FFFF);
    chk("reset_map_display[31]", 32'(map_display[31]), 32'd31);

    for (int i = 0; i < 5; i++) begin
      apply_vec(i);
    end

    // Table state after the vectors.
    @(negedge clock);
    idle_inputs();
    #1;
    chk("state_map[0]", 32'(map_display[0]), 32'd0);
    chk("state_ready[0]", 32'(ready_display[0]), 32'd1);
    chk("state_map[3]", 32'(map_display[3]), 32'd33);
    chk("state_ready[3]", 32'(ready_display[3]), 32'd1);
    chk("state_map[4]", 32'(map_display[4]), 32'd43);
    chk("state_ready[4]", 32'(ready_display[4]), 32'd0);
    chk("state_map[5]", 32'(map_display[5]), 32'd5);
    chk("state_ready[5]", 32'(ready_display[5]), 32'd1);

    // Recovery with a concurrent dispatch and CDB: both must be discarded.
    @(negedge clock);
    recover_en  = 1'b1;
    dispatch_en = 3'b111;
    dest_areg   = {5'd1, 5'd2, 5'd3};
    free_preg   = {6'd50, 6'd51, 6'd52};
    cdb_en      = 3'b111;
    cdb_preg    = {6'd43, 6'd2, 6'd3};
    @(negedge clock);
    idle_inputs();
    src1_areg = {5'd0, 5'd9, 5'd3};
    #1;
    for (int i = 0; i < 32; i++) begin
      chk($sformatf("recover_map[%0d]", i), 32'(map_display[i]), (i == 0) ? 32'd0 : 32'(i + 1));
    end
    chk("recover_ready_display", ready_display, 32'hFFFF_FFFF);
    chk("recover_src1_preg[0]", 32'(src1_preg[0]), 32'd4);
    chk("recover_src1_preg[1]", 32'(src1_preg[1]), 32'd10);
    chk("recover_src1_ready", 32'(src1_ready), 32'd7);

    // Dirty one entry, then reset together with recovery and a full dispatch.
    @(negedge clock);
    dispatch_en = 3'b001;
    dest_areg   = {5'd0, 5'd0, 5'd5};
    free_preg   = {6'd0, 6'd0, 6'd60};
    @(negedge clock);
    chk("pre_reset_map[5]", 32'(map_display[5]), 32'd60);
    reset       = 1'b1;
    recover_en  = 1'b1;
    dispatch_en = 3'b111;
    dest_areg   = {5'd5, 5'd6, 5'd7};
    free_preg   = {6'd61, 6'd62, 6'd63};
    @(negedge clock);
    reset = 1'b0;
    idle_inputs();
    dest_areg = {5'd0, 5'd6, 5'd7};
    free_preg = {6'd44, 6'd0, 6'd0};
    #1;
    for (int i = 0; i < 32; i++) begin
      chk($sformatf("reset_map[%0d]", i), 32'(map_display[i]), 32'(i));
    end
    chk("reset_ready_all", ready_display, 32'hFFFF_FFFF);
    chk("reset_told[0]", 32'(told_preg[0]), 32'd7);
    chk("reset_told[1]", 32'(told_preg[1]), 32'd6);
    chk("reset_told_x0[2]", 32'(told_preg[2]), 32'd44);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/map_table.md
Name: map_table

Overview:
- 3-wide register rename map table; sits directly downstream of the free list in the dispatch stage.
- Translates source architectural registers to physical tags and ready bits.
- Installs the free list's allocated tags as the new destination mappings and reports the previous mapping (Told) for each destination to the ROB.
- Ready bits are set by CDB broadcasts. On branch mispredict recovery, the table is restored from the retirement map.

Parameters:
- PR, 6, physical register tag width (64 physical registers)
- AR_NUM, 32, number of architectural registers (5-bit index)
- WAYS, 3, dispatch and CDB width

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high reset
- dispatch_en  in  3  per-lane dispatch valid; lane 2 is oldest, lane 0 is youngest
- dest_areg  in  3x5  destination architectural register per lane
- src1_areg  in  3x5  source 1 architectural register per lane
- src2_areg  in  3x5  source 2 architectural register per lane
- free_preg  in  3xPR  tag allocated by the free list per lane; valid where dispatch_en is set
- cdb_en  in  3  CDB broadcast valid per way
- cdb_preg  in  3xPR  completing physical tag per way
- recover_en  in  1  branch recovery; restore from arch_map
- arch_map  in  32xPR  retirement map contents
- src1_preg  out  3xPR  renamed source 1 tag
- src1_ready  out  3  source 1 value available
- src2_preg  out  3xPR  renamed source 2 tag
- src2_ready  out  3  source 2 value available
- told_preg  out  3xPR  previous mapping of the destination; freed at retire
- map_display  out  32xPR  debug view of the map entries
- ready_display  out  32  debug view of the ready bits

Behaviour:
- State: map[32] (PR bits each) and ready[32].
- Reset (synchronous): map[i] = i, ready[i] = 1 for all i.
  - This is disjoint from the free list's initial contents, 32..63.
  - Outputs are combinational, so right after reset src*_preg = src*_areg, src*_ready = 1, and told_preg = dest_areg.
- Rename lookup is combinational, zero latency. Map updates take effect at the next posedge.
- Source lookup for lane L:
  - Base value is map[src] and ready[src].
  - Override from older lanes in the same group: an older lane K (K > L) with dispatch_en[K], dest_areg[K] == src and dest_areg[K] != 0 supplies free_preg[K] with ready = 0.
  - If several older lanes match, the youngest of them (smallest K > L) wins.
- Told lookup for lane L follows the same override rule applied to dest_areg[L]: it returns the older in-group free_preg if one matches, else map[dest].
- CDB bypass on sources: the ready output is forced to 1 if any cdb_en[w] has cdb_preg[w] equal to the resolved tag. This does not apply to tags supplied by in-group overrides, since those are newly allocated and cannot be on the CDB.
- Map update at posedge, for each dispatching lane with dest_areg != 0:
  - map[dest] <= free_preg and ready[dest] <= 0.
  - If two lanes write the same dest, the youngest (lowest index) wins.
- x0 handling:
  - x0 is never remapped; map[0] stays 0 and ready[0] stays 1.
  - For dest_areg == 0, told_preg = free_preg of that lane. The allocated tag is then returned at retire and is not leaked.
- CDB update: for each cdb_en[w], every entry whose map equals cdb_preg[w] gets ready <= 1.
  - If a same-cycle rename writes the same entry, the rename's ready = 0 wins.
- Recovery: when recover_en is high, map <= arch_map and ready <= all 1.
  - Dispatch updates and CDB updates that cycle are discarded.
  - Combinational outputs that cycle are don't-care.
- Reset has priority over recovery. Reset mid-dispatch discards that cycle's updates.
- dispatch_en bits may be non-contiguous (e.g. 3'b101); lane age ordering still holds.

Test Plan:
- Post-reset, lane 0 reads src1 = 5, src2 = 0 -> src1_preg = 5, ready = 1; src2_preg = 0, ready = 1; told_preg for dest 7 = 7.
- dispatch_en = 111, dests 3, 3, 4, free_preg[2..0] = 32, 33, 34, lane 0 src1 = 3 -> lane 0 src1_preg = 33, ready = 0; lane 1 told = 32; lane 2 told = 3. Next cycle map[3] = 33, map[4] = 34, ready[3] = ready[4] = 0.
- With map[3] = 33 not ready, cdb_en = 001, cdb_preg = 33 while lane 1 reads src2 = 3 -> src2_ready = 1 same cycle; ready[3] = 1 next cycle.
- Lane 2 dest = 0, free_preg = 40 -> told_preg[2] = 40; map[0] remains 0.
- After several renames, recover_en with arch_map[i] = i + 1 (i ≠ 0) plus a concurrent dispatch -> next cycle map_display = arch_map, ready_display = all 1s, dispatch ignored.
- Reset asserted with recover_en and dispatch_en = 111 -> identity map, all ready.
